sound_pwm_out: RTL and testbench



---
 rtl/sound_pwm_out.sv | 105 ++++++++++
 tb/tb_sound_pwm_out.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_pwm_out.sv
// PWM speaker output stage with ramped volume/mute gain envelope.
// Optional SOUND_PWM_INSTANT_MUTE_EN: mute drops gain to 0 in one period.
module sound_pwm_out #(
  parameter int N            = 8,
  parameter int VOL_W        = 3,
  parameter int RAMP_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     sample_i,
  input  logic [VOL_W-1:0] volume_i,
  input  logic             mute_i,
  output logic             pwm_o,
  output logic             period_start_o,
  output logic [N-1:0]     level_o,
  output logic [VOL_W:0]   gain_o,
  output logic [1:0]       state_o
);

  localparam int RDW =
    (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RDW-1:0] RDIV_LAST = RDW'(RAMP_PERIODS - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  logic [N-1:0]     cnt_q, cnt_d;
  logic [N-1:0]     level_q, level_d;
  logic [VOL_W:0]   gain_q, gain_d;
  logic [RDW-1:0]   rdiv_q, rdiv_d;
  logic [1:0]       state_q, state_d;
  logic             ps_q, ps_d;

  logic             boundary;
  logic [VOL_W:0]   target;
  logic [N+VOL_W:0] prod;

  assign boundary = (cnt_q == '1);
  assign target   = mute_i ? '0
                  : {1'b0, volume_i} + (VOL_W+1)'(1);
  assign prod     = {{(VOL_W+1){1'b0}}, sample_i}
                  * {{N{1'b0}}, gain_q};

  always_comb begin
    cnt_d   = cnt_q + N'(1);
    ps_d    = boundary;
    level_d = level_q;
    gain_d  = gain_q;
    rdiv_d  = rdiv_q;
    state_d = state_q;
    if (boundary) begin
      // level uses the old gain; a new gain shows up next period
      level_d = N'(prod >> VOL_W);
      if (gain_q == target) begin
        rdiv_d = '0;
      end else if (rdiv_q == RDIV_LAST) begin
        rdiv_d = '0;
        if (gain_q < target) gain_d = gain_q + (VOL_W+1)'(1);
        else                 gain_d = gain_q - (VOL_W+1)'(1);
      end else begin
        rdiv_d = rdiv_q + RDW'(1);
      end
`ifdef SOUND_PWM_INSTANT_MUTE_EN
      if (mute_i) begin
        gain_d = '0;
        rdiv_d = '0;
      end
`endif
      unique case (1'b1)
        (gain_d < target): state_d = ST_RAMP_UP;
        (gain_d > target): state_d = ST_RAMP_DOWN;
        (gain_d == target && target == '0):
          state_d = ST_IDLE;
        default:           state_d = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= '0;
      gain_q  <= '0;
      rdiv_q  <= '0;
      state_q <= ST_IDLE;
      ps_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      gain_q  <= gain_d;
      rdiv_q  <= rdiv_d;
      state_q <= state_d;
      ps_q    <= ps_d;
    end
  end

  assign pwm_o          = (cnt_q < level_q);
  assign period_start_o = ps_q;
  assign level_o        = level_q;
  assign gain_o         = gain_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_sound_pwm_out.sv
// Scoreboard bench for sound_pwm_out: per-period gain/state/level
// expectations queued at stimulus time, checked at each period start.
module tb_sound_pwm_out;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_i = '0;
  logic [2:0] volume_i = '0;
  logic       mute_i = 1'b0;
  logic       pwm_o;
  logic       period_start_o;
  logic [7:0] level_o;
  logic [3:0] gain_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic [7:0] l;
  } exp_t;

  exp_t exp_q[$];

  sound_pwm_out #(.N(8), .VOL_W(3), .RAMP_PERIODS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample_i),
    .volume_i       (volume_i),
    .mute_i         (mute_i),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .level_o        (level_o),
    .gain_o         (gain_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int g, int s, int l);
    exp_t e;
    e.g = 4'(g);
    e.s = 2'(s);
    e.l = 8'(l);
    return e;
  endfunction

  // Advance to the cycle right after the next boundary edge.
  task automatic next_period();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!period_start_o && n < 300);
    checks++;
    if (!period_start_o) begin
      errors++;
      $display("FAIL period_timeout got %0d cycles need <=256", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_attack();
    exp_t e;
    int n = 0;
    int hi = 0;
    sample_i = 8'd128; volume_i = 3'd7; mute_i = 1'b0;
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      int g = (k / 4 > 8) ? 8 : k / 4;
      int gp = ((k - 1) / 4 > 8) ? 8 : (k - 1) / 4;
      exp_q.push_back(mk(g, (g == 8) ? 2 : 1, gp * 16));
    end
    do begin
      @(posedge clk); #1; n++;
    end while (!period_start_o && n < 300);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL first_pulse got %0d need 256", n);
    end
    for (int k = 1; k <= 33; k++) begin
      if (k > 1) next_period();
      e = exp_q.pop_front();
      checks++;
      if ({gain_o, state_o, level_o} !== {e.g, e.s, e.l}) begin
        errors++;
        $display("FAIL attack_b%0d got g%0d s%0d l%0d need g%0d s%0d l%0d",
                 k, gain_o, state_o, level_o, e.g, e.s, e.l);
      end
    end
    for (int i = 0; i < 256; i++) begin
      if (pwm_o) hi++;
      if (i < 255) begin @(posedge clk); #1; end
    end
    checks++;
    if (hi !== 128) begin
      errors++;
      $display("FAIL attack_duty got %0d need 128", hi);
    end
  endtask

  task automatic test_extremes();
    exp_t e;
    int lo = 0;
    int hi = 0;
    sample_i = 8'd255;
    exp_q.push_back(mk(8, 2, 255));
    next_period();
    e = exp_q.pop_front();
    checks++;
    if ({gain_o, state_o, level_o} !== {e.g, e.s, e.l}) begin
      errors++;
      $display("FAIL max_level got g%0d s%0d l%0d need g%0d s%0d l%0d",
               gain_o, state_o, level_o, e.g, e.s, e.l);
    end
    sample_i = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (!pwm_o) lo++;
      if (i < 255) begin @(posedge clk); #1; end
    end
    checks++;
    if (lo !== 1) begin
      errors++;
      $display("FAIL max_low_cycles got %0d need 1", lo);
    end
    exp_q.push_back(mk(8, 2, 0));
    next_period();
    e = exp_q.pop_front();
    checks++;
    if ({gain_o, state_o, level_o} !== {e.g, e.s, e.l}) begin
      errors++;
      $display("FAIL zero_level got g%0d s%0d l%0d need g%0d s%0d l%0d",
               gain_o, state_o, level_o, e.g, e.s, e.l);
    end
    for (int i = 0; i < 256; i++) begin
      if (pwm_o) hi++;
      if (i < 255) begin @(posedge clk); #1; end
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL zero_high_cycles got %0d need 0", hi);
    end
  endtask

  task automatic test_mid_sample();
    exp_t e;
    sample_i = 8'd200;
    exp_q.push_back(mk(8, 2, 200));
    exp_q.push_back(mk(8, 2, 200));
    exp_q.push_back(mk(8, 2, 40));
    next_period();
    e = exp_q.pop_front();
    checks++;
    if (level_o !== e.l) begin
      errors++;
      $display("FAIL mid_first got %0d need %0d", level_o, e.l);
    end
    repeat (100) begin @(posedge clk); #1; end
    sample_i = 8'd40;
    repeat (155) begin @(posedge clk); #1; end
    e = exp_q.pop_front();
    checks++;
    if (level_o !== e.l || period_start_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold got l%0d ps%0b need l%0d ps0",
               level_o, period_start_o, e.l);
    end
    next_period();
    e = exp_q.pop_front();
    checks++;
    if ({gain_o, state_o, level_o} !== {e.g, e.s, e.l}) begin
      errors++;
      $display("FAIL mid_new got g%0d s%0d l%0d need g%0d s%0d l%0d",
               gain_o, state_o, level_o, e.g, e.s, e.l);
    end
  endtask

  task automatic test_release();
    exp_t e;
    int hi = 0;
    sample_i = 8'd128;
    mute_i = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      int g = (8 - k / 4 < 0) ? 0 : 8 - k / 4;
      int gp = (8 - (k - 1) / 4 < 0) ? 0 : 8 - (k - 1) / 4;
      exp_q.push_back(mk(g, (g == 0) ? 0 : 3, gp * 16));
    end
    for (int k = 1; k <= 33; k++) begin
      next_period();
      e = exp_q.pop_front();
      checks++;
      if ({gain_o, state_o, level_o} !== {e.g, e.s, e.l}) begin
        errors++;
        $display("FAIL release_b%0d got g%0d s%0d l%0d need g%0d s%0d l%0d",
                 k, gain_o, state_o, level_o, e.g, e.s, e.l);
      end
    end
    for (int i = 0; i < 256; i++) begin
      if (pwm_o) hi++;
      if (i < 255) begin @(posedge clk); #1; end
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL release_pwm got %0d high need 0", hi);
    end
  endtask

  task automatic test_retarget();
    exp_t e;
    sample_i = 8'd128; volume_i = 3'd7; mute_i = 1'b0;
    for (int k = 1; k <= 13; k++)
      exp_q.push_back(mk(k / 4, 1, ((k - 1) / 4) * 16));
    exp_q.push_back(mk(3, 3, 48));
    exp_q.push_back(mk(3, 3, 48));
    exp_q.push_back(mk(2, 2, 48));
    exp_q.push_back(mk(2, 2, 32));
    for (int k = 1; k <= 17; k++) begin
      next_period();
      if (k == 13) volume_i = 3'd1;
      e = exp_q.pop_front();
      checks++;
      if ({gain_o, state_o, level_o} !== {e.g, e.s, e.l}) begin
        errors++;
        $display("FAIL retarget_b%0d got g%0d s%0d l%0d need g%0d s%0d l%0d",
                 k, gain_o, state_o, level_o, e.g, e.s, e.l);
      end
    end
  endtask

  task automatic test_reset();
    int p = 0;
    int n = 0;
    volume_i = 3'd7;
    while (gain_o !== 4'd5 && p < 20) begin
      next_period();
      p++;
    end
    checks++;
    if (gain_o !== 4'd5) begin
      errors++;
      $display("FAIL pre_reset_gain got %0d need 5", gain_o);
    end
    repeat (100) begin @(posedge clk); #1; end
    exp_q.push_back(mk(0, 0, 0));
    do_reset();
    begin
      exp_t e = exp_q.pop_front();
      checks++;
      if ({gain_o, state_o, level_o} !== {e.g, e.s, e.l}
          || pwm_o !== 1'b0 || period_start_o !== 1'b0) begin
        errors++;
        $display("FAIL reset got g%0d s%0d l%0d p%0b ps%0b need all 0",
                 gain_o, state_o, level_o, pwm_o, period_start_o);
      end
    end
    do begin
      @(posedge clk); #1; n++;
    end while (!period_start_o && n < 300);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL reset_first_pulse got %0d need 256", n);
    end
  endtask

  initial begin
    test_attack();
    test_extremes();
    test_mid_sample();
    test_release();
    test_retarget();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
